mmio_bus_router: RTL
====================

MMIO_BUS_ROUTER -- requirements
Module: mmio_bus_router

Interface
REQ-001 SHALL have parameter NCH, default 4: number of slave channels (1..8).
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter BASE, default {32'h0A00,32'h0900,32'h0800,32'h0000}: packed NCH x 32 channel base addresses, channel 0 in the LSBs.
REQ-004 SHALL have parameter MASK, default {32'hFFFF_FFF0 x3, 32'hFFFF_FF00}: packed NCH x 32 match masks.
REQ-005 SHALL have parameter TIMEOUT, default 15: maximum ACCESS wait cycles (1..255).
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 m_req  in  1  master request; held with m_we/m_addr/m_wdata until m_ready.
REQ-009 m_we  in  1  write when 1, read when 0.
REQ-010 m_addr  in  32  byte address.
REQ-011 m_wdata  in  DW  write data.
REQ-012 m_ready  out  1  one-cycle completion pulse.
REQ-013 m_rdata  out  DW  read data, valid while m_ready=1.
REQ-014 m_err  out  1  error flag, valid while m_ready=1.
REQ-015 s_sel  out  NCH  one-hot channel select.
REQ-016 s_we  out  NCH  per-channel write enable (s_sel & latched we).
REQ-017 s_addr  out  32 and s_wdata out DW: latched request fields, shared by all channels.
REQ-018 s_ready  in  NCH and s_rdata in NCH*DW: per-channel completion and read data.
REQ-019 err_cnt  out  8  saturating count of error completions.

Function
REQ-020 Decode: channel i SHALL match when (m_addr & MASK[i]) == BASE[i]. When several channels match, the lowest index SHALL win.
REQ-021 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-022 IDLE with m_req=1 SHALL latch addr, we, wdata and the decoded channel. It SHALL go to ACCESS if the address matched, else to RESP with err=1 and rdata=0.
REQ-023 ACCESS SHALL drive s_sel/s_we for the latched channel only and increment the wait counter each cycle.
REQ-024 ACCESS with s_ready[ch]=1 SHALL register s_rdata[ch] (zero when writing) and go to RESP with err=0. s_ready of non-selected channels SHALL be ignored.
REQ-025 ACCESS with wait counter == TIMEOUT-1 and no s_ready SHALL go to RESP with err=1 and rdata=0. A ready arriving in that same cycle SHALL win (err=0).
REQ-026 RESP SHALL assert m_ready for exactly one cycle, then return to IDLE. A new request SHALL be accepted no earlier than the following IDLE cycle.
REQ-027 Latency: a mapped access whose slave is ready on its first select cycle SHALL give m_ready 2 cycles after acceptance. An unmapped access SHALL give m_ready 1 cycle after acceptance.
REQ-028 s_sel and s_we SHALL be 0 in IDLE and RESP. s_we SHALL never assert for an unmapped address.
REQ-029 m_rdata, m_err and m_ready SHALL all be 0 outside RESP.
REQ-030 err_cnt SHALL increment on each RESP with err=1 and saturate at 255.

Reset
REQ-031 rst=1 SHALL force, on the next edge: IDLE; wait counter 0; err_cnt 0; all outputs 0. This applies from any state and drops any in-flight access with no m_ready.
REQ-032 Outputs SHALL be 0 in the first cycle after reset deassertion. m_req sampled in that cycle SHALL be accepted normally.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE/ACCESS/RESP) and the default 4-channel BASE/MASK constants.
REQ-034 Address matching SHALL be a sub-module mmio_addr_match: combinational, parametrised by NCH/BASE/MASK, outputting a one-hot hit and a hit-valid flag. The FSM, counters and data registers SHALL live in mmio_bus_router.

Verification
REQ-035 Write, addr 0x0000_0010, wdata 0xDEADBEEF, s_ready[0] tied 1 -> s_we=4'b0001 for 1 cycle with s_wdata=0xDEADBEEF; m_ready 2 cycles after acceptance; m_err=0.
REQ-036 Read, addr 0x0000_0904, s_ready[2] asserted on the 3rd ACCESS cycle with s_rdata[2]=0x12345678 -> m_rdata=0x12345678 and m_err=0 in the RESP cycle; s_we=0 throughout.
REQ-037 Write, addr 0x0000_0B00 (unmapped) -> s_sel never asserted; m_ready 1 cycle after acceptance; m_err=1; err_cnt 0->1.
REQ-038 Read, addr 0x0000_0A08, s_ready held 0 -> exactly 15 ACCESS cycles, then m_ready=1, m_err=1, m_rdata=0; a repeat with ready on the 15th cycle -> m_err=0.
REQ-039 rst=1 during ACCESS for a 0x0800 write -> next cycle: s_sel=0, no m_ready, err_cnt=0; a new request after release completes normally.
REQ-040 300 unmapped accesses -> err_cnt saturates at 255.

Source files
------------

// File: rtl/mmio_bus_router_pkg.sv
// Shared types and default address map for the MMIO bus router.
package mmio_bus_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int unsigned DEF_NCH = 4;

  // Channel 0 sits in the LSBs.
  localparam logic [DEF_NCH*32-1:0] DEF_BASE = {
    32'h0000_0A00, 32'h0000_0900, 32'h0000_0800, 32'h0000_0000
  };

  localparam logic [DEF_NCH*32-1:0] DEF_MASK = {
    32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FF00
  };

endpackage

// File: rtl/mmio_addr_match.sv
// Combinational address decoder: one-hot hit, lowest matching channel wins.
module mmio_addr_match
  import mmio_bus_router_pkg::*;
#(
  parameter int unsigned          NCH  = 4,
  parameter logic [NCH*32-1:0]    BASE = DEF_BASE,
  parameter logic [NCH*32-1:0]    MASK = DEF_MASK
) (
  input  logic [31:0]    addr,
  output logic [NCH-1:0] hit,
  output logic           hit_valid
);

  // Scan channels upward; the first match blocks all later ones.
  always_comb begin
    hit       = '0;
    hit_valid = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!hit_valid && ((addr & MASK[i*32 +: 32]) == BASE[i*32 +: 32])) begin
        hit[i]    = 1'b1;
        hit_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_bus_router.sv
// Single-master MMIO router: decodes, forwards to one slave channel, waits
// for its ready with a timeout, and returns a one-cycle completion.
module mmio_bus_router
  import mmio_bus_router_pkg::*;
#(
  parameter int unsigned        NCH     = 4,
  parameter int unsigned        DW      = 32,
  parameter logic [NCH*32-1:0]  BASE    = DEF_BASE,
  parameter logic [NCH*32-1:0]  MASK    = DEF_MASK,
  parameter int unsigned        TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [31:0]       m_addr,
  input  logic [DW-1:0]     m_wdata,
  output logic              m_ready,
  output logic [DW-1:0]     m_rdata,
  output logic              m_err,
  output logic [NCH-1:0]    s_sel,
  output logic [NCH-1:0]    s_we,
  output logic [31:0]       s_addr,
  output logic [DW-1:0]     s_wdata,
  input  logic [NCH-1:0]    s_ready,
  input  logic [NCH*DW-1:0] s_rdata,
  output logic [7:0]        err_cnt
);

  state_t          state, state_next;
  logic [NCH-1:0]  hit;
  logic            hit_valid;
  logic [NCH-1:0]  ch_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic [7:0]      wait_cnt;
  logic            ch_ready;
  logic [DW-1:0]   ch_rdata;
  logic            timeout_hit;

  mmio_addr_match #(
    .NCH  (NCH),
    .BASE (BASE),
    .MASK (MASK)
  ) u_match (
    .addr      (m_addr),
    .hit       (hit),
    .hit_valid (hit_valid)
  );

  // Ready and read data of the latched channel only; others are ignored.
  always_comb begin
    ch_ready    = |(s_ready & ch_q);
    ch_rdata    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_q[i]) begin
        ch_rdata = ch_rdata | s_rdata[i*DW +: DW];
      end
    end
    timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a ready in the timeout cycle still completes cleanly.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (m_req) state_next = hit_valid ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (ch_ready || timeout_hit) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Request latch, wait counter, response registers and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_req) begin
            ch_q     <= hit;
            we_q     <= m_we;
            addr_q   <= m_addr;
            wdata_q  <= m_wdata;
            wait_cnt <= '0;
            err_q    <= ~hit_valid;
            rdata_q  <= '0;
          end
        end
        ST_ACCESS: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (ch_ready) begin
            err_q   <= 1'b0;
            rdata_q <= we_q ? '0 : ch_rdata;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        ST_RESP: begin
          if (err_q && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are qualified by state so they read zero outside their phase.
  always_comb begin
    s_sel   = (state == ST_ACCESS) ? ch_q : '0;
    s_we    = s_sel & {NCH{we_q}};
    s_addr  = addr_q;
    s_wdata = wdata_q;
    m_ready = (state == ST_RESP);
    m_err   = m_ready & err_q;
    m_rdata = m_ready ? rdata_q : '0;
  end

endmodule
